i2c_rr_ctrl: RTL
================

I2C_RR_CTRL -- requirements
Module: i2c_rr_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; clock port clk, reset port rst.
REQ-002 Parameter TIMEOUT, 16'hFFFF: clk cycles allowed in WAIT before abort.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  2  per-requester transaction request; held until req_ready.
REQ-006 req_rw  in  2  per-requester direction; 0 = write, 1 = read.
REQ-007 req_data  in  16  write bytes; requester i uses bits [8i+7:8i].
REQ-008 req_ready  out  2  one-cycle accept pulse to the granted requester.
REQ-009 resp_valid  out  2  one-cycle completion pulse to the granted requester.
REQ-010 resp_data  out  8  read byte, valid with resp_valid; 0 for writes.
REQ-011 resp_err  out  1  timeout flag, valid with resp_valid.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 m_start  out  1  start pulse to the I2C master.
REQ-014 m_rw  out  1  direction to the master.
REQ-015 m_din  out  8  write byte to the master.
REQ-016 m_done  in  1  master completion pulse, one cycle wide.
REQ-017 m_rx_data  in  8  master read byte, valid when m_done=1.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; every output SHALL be registered.
REQ-019 IDLE: if any req_valid is high, the module SHALL pick a grant, load m_rw and m_din from that requester, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; after reset the last-grant pointer SHALL point at requester 1, so requester 0 wins first.
REQ-021 ISSUE, exactly one cycle: m_start=1 and req_ready[grant]=1; timeout counter cleared; next state WAIT.
REQ-022 Latency: req_valid sampled in IDLE at cycle N -> req_ready and m_start high at N+1 only.
REQ-023 m_rw and m_din SHALL hold stable from ISSUE until the next ISSUE.
REQ-024 WAIT: m_start=0; the 16-bit counter SHALL increment each cycle.
REQ-025 In WAIT, m_done=1 SHALL latch m_rx_data (or 0 when m_rw=0) and set err=0; next state RESP.
REQ-026 In WAIT, counter==TIMEOUT-1 with m_done=0 SHALL set err=1 and data=0; next state RESP.
REQ-027 If m_done and the timeout condition coincide, m_done SHALL win (err=0).
REQ-028 RESP, one cycle: resp_valid[grant]=1 with resp_data and resp_err; update the last-grant pointer; next state IDLE.
REQ-029 m_done outside WAIT SHALL be ignored.
REQ-030 req_valid changes outside IDLE SHALL be ignored; a request still held after RESP is re-arbitrated in IDLE.
REQ-031 Back-to-back throughput: with both requesters held valid, grants SHALL alternate 0,1,0,1.

Reset
REQ-032 On rst, the module SHALL enter IDLE and clear m_start, req_ready, resp_valid, resp_err, busy, resp_data, m_rw, m_din and the counter; the pointer SHALL be set to 1.
REQ-033 rst asserted mid-transaction SHALL abort with no resp_valid, and m_start SHALL stay low until a new request is made.

Structure
REQ-034 Package i2c_ctrl_pkg SHALL hold the state encoding, the TIMEOUT default and the requester count (2).
REQ-035 Sub-module rr_arb2 (inputs: valid[1:0], last pointer; output: grant index) SHALL hold the round-robin pick.

Verification
REQ-036 req0 write 0xA5 -> m_start one cycle, m_din=0xA5, m_rw=0; m_done -> resp_valid[0] next cycle, resp_err=0, resp_data=0x00.
REQ-037 req1 read, m_rx_data=0x3C at m_done -> resp_valid[1], resp_data=0x3C, resp_err=0.
REQ-038 Both valid from reset, held -> grant order 0,1,0,1; each req_ready is a one-cycle pulse.
REQ-039 TIMEOUT=16, m_done never asserted -> resp_valid on the cycle after count 15, resp_err=1, resp_data=0x00, then IDLE.
REQ-040 rst in WAIT -> busy=0 next cycle, no resp_valid, and a later m_done pulse is ignored.
REQ-041 m_done on the same cycle as the timeout -> resp_err=0 and resp_data=m_rx_data.

Source files
------------

// File: rtl/i2c_ctrl_pkg.sv
// Shared types and defaults for the round-robin I2C transaction controller.
package i2c_ctrl_pkg;

  localparam int unsigned NumReq         = 2;
  localparam logic [15:0] TimeoutDefault = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the requester not served last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    unique case (valid)
      2'b11:   grant = ~last;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/i2c_rr_ctrl.sv
// Arbitrates two requesters onto one I2C master; one transaction in flight at a time,
// every output registered, with a WAIT-state timeout that reports an error response.
module i2c_rr_ctrl
  import i2c_ctrl_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TimeoutDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req_valid,
  input  logic [NumReq-1:0] req_rw,
  input  logic [15:0]       req_data,
  output logic [NumReq-1:0] req_ready,
  output logic [NumReq-1:0] resp_valid,
  output logic [7:0]        resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic              m_start,
  output logic              m_rw,
  output logic [7:0]        m_din,
  input  logic              m_done,
  input  logic [7:0]        m_rx_data
);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              arb_grant;
  logic [15:0]       cnt_q, cnt_d;
  logic [NumReq-1:0] req_ready_d, resp_valid_d;
  logic [7:0]        resp_data_d, m_din_d;
  logic              resp_err_d, m_start_d, m_rw_d;

  rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last_q),
    .grant (arb_grant)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_data_d  = resp_data;
    resp_err_d   = resp_err;
    m_start_d    = 1'b0;
    m_rw_d       = m_rw;
    m_din_d      = m_din;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          grant_d                = arb_grant;
          m_rw_d                 = req_rw[arb_grant];
          m_din_d                = arb_grant ? req_data[15:8] : req_data[7:0];
          m_start_d              = 1'b1;
          req_ready_d[arb_grant] = 1'b1;
          state_d                = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        // A completion on the timeout cycle still counts as success.
        if (m_done) begin
          resp_data_d           = m_rw ? m_rx_data : 8'h00;
          resp_err_d            = 1'b0;
          resp_valid_d[grant_q] = 1'b1;
          state_d               = StResp;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          resp_data_d           = 8'h00;
          resp_err_d            = 1'b1;
          resp_valid_d[grant_q] = 1'b1;
          state_d               = StResp;
        end
      end
      StResp: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      m_start    <= 1'b0;
      m_rw       <= 1'b0;
      m_din      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
      busy       <= (state_d != StIdle);
      m_start    <= m_start_d;
      m_rw       <= m_rw_d;
      m_din      <= m_din_d;
    end
  end

endmodule
